phy_pipe_stage_hs: RTL

- Parametrised successor to the single-stage data/valid retiming flop used between PHY stages.
- Provides DEPTH registered stages over LANES lanes of LANE_W bits, with a valid/ready handshake.
- Bubble-collapsing behaviour, synchronous flush and an occupancy count.
- Sits between PHY TX/RX processing stages in the clk_2f domain wherever downstream can stall.

---
 rtl/phy_pipe_pkg.sv | 17 +
 rtl/phy_pipe_cell.sv | 32 +++
 rtl/phy_pipe_stage_hs.sv | 88 ++++++++
 3 files changed

// File: rtl/phy_pipe_pkg.sv
// Shared constants and helpers for the PHY handshake pipeline stage.
package phy_pipe_pkg;

    localparam int PIPE_LANE_W = 8;
    localparam int PIPE_DEPTH  = 2;

    // Smallest count width able to represent 0..depth inclusive.
    function automatic int cnt_w_for(input int depth);
        int w;
        w = 1;
        while ((1 << w) <= depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/phy_pipe_cell.sv
// One register stage of the handshake pipeline: a valid flag plus a data word.
module phy_pipe_cell
    import phy_pipe_pkg::*;
#(
    parameter int DW = PIPE_LANE_W
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic          flush,
    input  logic          load,
    input  logic          empty,
    input  logic [DW-1:0] d_in,
    output logic          v,
    output logic [DW-1:0] d
);

    // Load wins over empty; flush drops valid but leaves the data word untouched.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= 1'b1;
            d <= d_in;
        end else if (empty) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/phy_pipe_stage_hs.sv
// Multi-stage valid/ready retiming pipeline between PHY processing stages.
// Empty stages collapse so the chain fills completely while downstream stalls.
module phy_pipe_stage_hs
    import phy_pipe_pkg::*;
#(
    parameter int LANE_W = PIPE_LANE_W,
    parameter int LANES  = 1,
    parameter int DEPTH  = PIPE_DEPTH,
    parameter int CNT_W  = 4
) (
    input  logic                    clk_2f,
    input  logic                    reset,
    input  logic [LANE_W*LANES-1:0] data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [LANE_W*LANES-1:0] data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    input  logic                    flush,
    output logic [CNT_W-1:0]        count
);

    localparam int DW        = LANE_W * LANES;
    localparam int MIN_CNT_W = cnt_w_for(DEPTH);

    if (CNT_W < MIN_CNT_W) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEPTH");
    end

    logic [DEPTH-1:0]         v;
    logic [DEPTH-1:0]         adv;
    logic [DEPTH-1:0][DW-1:0] d;
    logic                     in_xfer;
    logic                     out_xfer;

    // A stage advances when it holds data and the next stage is empty or itself advancing.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v[DEPTH-1] & ready_in;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign ready_out = ~flush & (~v[0] | adv[0]);
    assign in_xfer   = valid_in & ready_out;
    assign out_xfer  = adv[DEPTH-1];
    assign data_out  = d[DEPTH-1];
    assign valid_out = v[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            phy_pipe_cell #(.DW(DW)) u_cell (
                .clk_2f (clk_2f),
                .reset  (reset),
                .flush  (flush),
                .load   (in_xfer),
                .empty  (adv[0]),
                .d_in   (data_in),
                .v      (v[0]),
                .d      (d[0])
            );
        end else begin : g_body
            phy_pipe_cell #(.DW(DW)) u_cell (
                .clk_2f (clk_2f),
                .reset  (reset),
                .flush  (flush),
                .load   (adv[i-1]),
                .empty  (adv[i]),
                .d_in   (d[i-1]),
                .v      (v[i]),
                .d      (d[i])
            );
        end
    end

    // Occupancy tracks accepted minus delivered words; flush empties everything.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

endmodule
